// File: rtl/slot_reel_renderer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : slot_pkg
// Description : Shared geometry, reel state encoding and colour tables for
//               the slot-machine reel renderer.
// Revision    : 1.0 - initial release
// ============================================================================
package slot_pkg;

    localparam int unsigned NUM_REELS = 3;
    localparam int unsigned WIN_X0    = 128;
    localparam int unsigned WIN_PITCH = 128;
    localparam int unsigned WIN_W     = 112;
    localparam int unsigned WIN_Y0    = 144;
    localparam int unsigned WIN_H     = 192;
    localparam int unsigned SEP_W     = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SPINNING = 2'd1,
        STOPPING = 2'd2
    } reel_state_t;

    localparam logic [11:0] SYM_COLOR [8] = '{
        12'hF00, 12'h0F0, 12'h00F, 12'hFF0,
        12'hF0F, 12'h0FF, 12'hF80, 12'hFFF
    };

    localparam logic [11:0] BG_COLOR = 12'h224;

    // Each reel's strip is the same sequence rotated by three symbols.
    function automatic logic [2:0] sym_index(input logic [2:0] row, input logic [1:0] reel);
        return row + {1'b0, reel} + {reel, 1'b0};
    endfunction

endpackage
`default_nettype wire

// File: rtl/slot_reel_renderer_reel.sv
`default_nettype none
// ============================================================================
// Module      : slot_reel
// Description : One reel: spin/stop state machine and 9-bit strip offset.
// Revision    : 1.0 - initial release
// ============================================================================
module slot_reel
    import slot_pkg::*;
#(
    parameter int SPEED = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        tick_i,
    input  logic        start_i,
    input  logic        stop_i,
    output logic [8:0]  offset_o,
    output reel_state_t state_o,
    output logic        idle_o
);

    localparam logic [8:0] C_STEP = 9'(SPEED);

    reel_state_t state_q, state_d;
    logic [8:0]  offset_q, offset_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            offset_q <= '0;
        end else begin
            state_q  <= state_d;
            offset_q <= offset_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        offset_d = offset_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = SPINNING;
                end
            end
            SPINNING: begin
                if (tick_i) begin
                    offset_d = offset_q + C_STEP;
                end
                if (stop_i) begin
                    state_d = STOPPING;
                end
            end
            STOPPING: begin
                // Always step at least once, so an already-aligned reel
                // travels to the next symbol boundary before halting.
                if (tick_i) begin
                    offset_d = offset_q + C_STEP;
                    if (offset_d[5:0] == 6'd0) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign offset_o = offset_q;
    assign state_o  = state_q;
    assign idle_o   = (state_q == IDLE);

endmodule
`default_nettype wire

// File: rtl/slot_reel_renderer.sv
`default_nettype none
// ============================================================================
// Module      : slot_reel_renderer
// Description : Two-stage pixel pipeline drawing three slot reels, with reel
//               motion advanced once per frame during vertical blanking.
// Revision    : 1.0 - initial release
// ============================================================================
module slot_reel_renderer
    import slot_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int SPEED    = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    input  logic        active_video,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        spin_start,
    input  logic [2:0]  stop_req,
    output logic [11:0] rgb,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic        busy,
    output logic        done,
    output logic [8:0]  result
);

    logic [8:0]  offset [NUM_REELS];
    reel_state_t state  [NUM_REELS];
    logic [2:0]  idle;
    logic        frame_tick;
    logic        spin_go;

    assign frame_tick = (hcount == 11'd0) && (vcount == 10'(V_ACTIVE));
    assign spin_go    = spin_start && (&idle);

    for (genvar i = 0; i < NUM_REELS; i++) begin : g_reel
        slot_reel #(
            .SPEED (SPEED)
        ) u_reel (
            .clk      (clk),
            .reset_n  (reset_n),
            .tick_i   (frame_tick),
            .start_i  (spin_go),
            .stop_i   (stop_req[i]),
            .offset_o (offset[i]),
            .state_o  (state[i]),
            .idle_o   (idle[i])
        );

        // Centre row of the window sits one symbol below the strip position.
        assign result[3*i +: 3] = offset[i][8:6] + 3'd1 + 3'(3 * i);
    end

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < NUM_REELS; i++) begin
            if (state[i] != IDLE) begin
                busy = 1'b1;
            end
        end
    end

    logic busy_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q <= 1'b0;
        end else begin
            busy_q <= busy;
        end
    end

    assign done = busy_q && !busy;

    // Stage 1: window hit, separator test and symbol index.
    logic        s1_hit_d, s1_sep_d;
    logic [2:0]  s1_sym_d;
    logic        s1_hit_q, s1_sep_q, s1_act_q, s1_hs_q, s1_vs_q;
    logic [2:0]  s1_sym_q;
    logic        in_y;
    logic [8:0]  dy;
    logic [10:0] lx;
    logic [8:0]  pos;

    always_comb begin
        s1_hit_d = 1'b0;
        s1_sep_d = 1'b0;
        s1_sym_d = '0;
        lx       = '0;
        pos      = '0;
        in_y     = (vcount >= 10'(WIN_Y0)) && (vcount < 10'(WIN_Y0 + WIN_H));
        dy       = vcount[8:0] - 9'(WIN_Y0);
        for (int i = 0; i < NUM_REELS; i++) begin
            lx  = hcount - 11'(WIN_X0 + WIN_PITCH * i);
            pos = dy + offset[i];
            if (in_y && (hcount >= 11'(WIN_X0 + WIN_PITCH * i)) &&
                (lx < 11'(WIN_W)) && (hcount < 11'(H_ACTIVE))) begin
                s1_hit_d = 1'b1;
                s1_sep_d = (lx < 11'(SEP_W)) || (pos[5:0] < 6'(SEP_W));
                s1_sym_d = sym_index(pos[8:6], 2'(i));
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_hit_q <= 1'b0;
            s1_sep_q <= 1'b0;
            s1_sym_q <= '0;
            s1_act_q <= 1'b0;
            s1_hs_q  <= 1'b0;
            s1_vs_q  <= 1'b0;
        end else begin
            s1_hit_q <= s1_hit_d;
            s1_sep_q <= s1_sep_d;
            s1_sym_q <= s1_sym_d;
            s1_act_q <= active_video;
            s1_hs_q  <= hsync;
            s1_vs_q  <= vsync;
        end
    end

    // Stage 2: colour lookup.
    logic [11:0] rgb_d;
    logic [11:0] rgb_q;
    logic        hs_q, vs_q;

    always_comb begin
        rgb_d = '0;
        if (s1_act_q) begin
            if (s1_hit_q) begin
                rgb_d = s1_sep_q ? 12'h000 : SYM_COLOR[s1_sym_q];
            end else begin
                rgb_d = BG_COLOR;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rgb_q <= '0;
            hs_q  <= 1'b0;
            vs_q  <= 1'b0;
        end else begin
            rgb_q <= rgb_d;
            hs_q  <= s1_hs_q;
            vs_q  <= s1_vs_q;
        end
    end

    assign rgb     = rgb_q;
    assign hsync_o = hs_q;
    assign vsync_o = vs_q;

endmodule
`default_nettype wire
